// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the word-serial
// wrapper around the wide ALU.
package alu_pkg;

   localparam int OPCODE_WIDTH = 3;

   localparam logic [OPCODE_WIDTH-1:0] PARITY   = 3'b000;
   localparam logic [OPCODE_WIDTH-1:0] POPCOUNT = 3'b001;
   localparam logic [OPCODE_WIDTH-1:0] ROTR     = 3'b010;
   localparam logic [OPCODE_WIDTH-1:0] ROTL     = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_WAIT,
      S_DRAIN
   } seq_state_e;

   // Counter width able to index 0..n-1; never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_result_serializer.sv
// Holds the captured ALU result and presents it one word per handshake,
// least-significant word first.
module alu_result_serializer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 1024,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  capture_i,
   input  logic [DATA_WIDTH-1:0] result_i,
   input  logic                  drain_i,
   input  logic                  out_ready_i,
   output logic                  out_valid_o,
   output logic [WORD_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  done_o
);

   localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
   localparam int IW        = idx_width(NUM_WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

   logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] result_q;
   logic [IW-1:0]                        idx_q, idx_d;
   logic                                 xfer;

   // Valid comes from the sequencer state only, so data and last hold
   // through any out_ready stall.
   assign out_valid_o = drain_i;
   assign out_last_o  = drain_i && (idx_q == LAST_IDX);
   assign out_data_o  = result_q[idx_q];
   assign xfer        = drain_i && out_ready_i;
   assign done_o      = xfer && (idx_q == LAST_IDX);

   always_comb begin
      idx_d = idx_q;
      if (capture_i || done_o) begin
         idx_d = '0;
      end else if (xfer) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         idx_q    <= '0;
      end else begin
         if (capture_i) begin
            result_q <= result_i;
         end
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Word-serial front/back end for the wide ALU: takes an opcode, streams in
// A then B, waits out the ALU latency and streams the result back.
module alu_operand_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 1024,
   parameter int WORD_WIDTH  = 32,
   parameter int ALU_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_WIDTH-1:0]   out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic [OPCODE_WIDTH-1:0] alu_opcode,
   output logic [DATA_WIDTH-1:0]   alu_a,
   output logic [DATA_WIDTH-1:0]   alu_b,
   input  logic [DATA_WIDTH-1:0]   alu_result
);

   localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
   localparam int CW        = idx_width(NUM_WORDS);
   localparam int LW        = idx_width(ALU_LATENCY + 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
   localparam logic [LW-1:0] LAT_DONE  = LW'(ALU_LATENCY);

   seq_state_e                           state_q, state_d;
   logic [CW-1:0]                        wcnt_q, wcnt_d;
   logic [LW-1:0]                        wait_q, wait_d;
   logic [OPCODE_WIDTH-1:0]              op_q, op_d;
   logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] a_q, b_q;
   logic                                 in_xfer;
   logic                                 capture;
   logic                                 drain_done;

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign in_ready   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign in_xfer    = in_valid && in_ready;
   assign alu_opcode = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      wait_d  = wait_q;
      op_d    = op_q;
      capture = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_opcode;
               wcnt_d  = '0;
               state_d = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            if (in_valid) begin
               if (wcnt_q == LAST_WORD) begin
                  wcnt_d  = '0;
                  state_d = S_LOAD_B;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         S_LOAD_B: begin
            if (in_valid) begin
               if (wcnt_q == LAST_WORD) begin
                  wcnt_d  = '0;
                  wait_d  = '0;
                  state_d = S_WAIT;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         S_WAIT: begin
            // Operands have been stable since the last B word; the ALU output
            // is valid once ALU_LATENCY further edges have passed.
            if (wait_q == LAT_DONE) begin
               capture = 1'b1;
               state_d = S_DRAIN;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         wait_q  <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         wait_q  <= wait_d;
         op_q    <= op_d;
         if (in_xfer) begin
            if (state_q == S_LOAD_A) begin
               a_q[wcnt_q] <= in_data;
            end else begin
               b_q[wcnt_q] <= in_data;
            end
         end
      end
   end

   alu_result_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_ser (
      .clk         (clk),
      .rst_n       (rst_n),
      .capture_i   (capture),
      .result_i    (alu_result),
      .drain_i     (state_q == S_DRAIN),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .done_o      (drain_done)
   );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed plus randomized bench: a stand-in ALU with one cycle of latency
// feeds the sequencer, and results are compared against a reference model.
module tb_alu_operand_sequencer;
   import alu_pkg::*;

   localparam int DW  = 1024;
   localparam int WW  = 32;
   localparam int LAT = 1;
   localparam int NW  = DW / WW;

   typedef logic [NW-1:0][WW-1:0] words_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_opcode = 3'd0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [WW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic [2:0]    alu_opcode;
   logic [DW-1:0] alu_a, alu_b;
   logic [DW-1:0] alu_result = '0;

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_operand_sequencer #(
      .DATA_WIDTH (DW),
      .WORD_WIDTH (WW),
      .ALU_LATENCY(LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result)
   );

   // Stand-in ALU: bit-level loops, registered once (ALU_LATENCY = 1).
   function automatic logic [DW-1:0] alu_model(input logic [2:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
      logic [DW-1:0] r;
      int sh;
      r  = '0;
      sh = int'(b[$clog2(DW)-1:0]);
      case (op)
         PARITY:   r[0] = ^a;
         POPCOUNT: r = DW'($countones(a));
         ROTR:     for (int i = 0; i < DW; i++) r[i] = a[(i + sh) % DW];
         ROTL:     for (int i = 0; i < DW; i++) r[(i + sh) % DW] = a[i];
         default:  r = a ^ b;
      endcase
      return r;
   endfunction

   always @(posedge clk) alu_result <= alu_model(alu_opcode, alu_a, alu_b);

   // Reference: expected result straight from the operand words the bench sent.
   function automatic words_t ref_result(input logic [2:0] op, input words_t a,
                                         input words_t b);
      logic [DW-1:0] av, bv, r;
      int unsigned ones, s;
      av   = a;
      bv   = b;
      ones = 0;
      for (int i = 0; i < DW; i++) ones += 32'(av[i]);
      s = b[0] % DW;
      case (op)
         PARITY:   r = DW'(ones % 2);
         POPCOUNT: r = DW'(ones);
         ROTR:     r = (av >> s) | (av << (DW - s));
         ROTL:     r = (av << s) | (av >> (DW - s));
         default:  r = av ^ bv;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (low 128 bits)", tag,
                obs[127:0], exp[127:0]);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".cmd_ready"}, cmd_ready, 1);
      chk({tag, ".in_ready"}, in_ready, 0);
      chk({tag, ".out_valid"}, out_valid, 0);
      chk({tag, ".out_last"}, out_last, 0);
      chk({tag, ".out_data"}, out_data, 0);
      chk({tag, ".alu_opcode"}, alu_opcode, 0);
      chk({tag, ".alu_a"}, alu_a, 0);
      chk({tag, ".alu_b"}, alu_b, 0);
   endtask

   // All tasks start and end on a falling edge; inputs change only there.
   task automatic send_cmd(input logic [2:0] op, input string tag);
      int t;
      t = 0;
      while (!cmd_ready && t < 200) begin
         @(posedge clk); @(negedge clk); t++;
      end
      chk({tag, ".cmd_ready"}, cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, ".cmd_taken"}, {busy, alu_opcode}, {1'b1, op});
   endtask

   task automatic load(input words_t a, input words_t b, input int gapmax,
                       input int nsend, output int unsigned hs_cyc);
      int t;
      hs_cyc = 0;
      for (int i = 0; i < nsend; i++) begin
         if (gapmax > 0) begin
            repeat ($urandom_range(gapmax, 0)) begin
               in_valid = 1'b0;
               in_data  = $urandom;
               @(posedge clk); @(negedge clk);
            end
         end
         t = 0;
         while (!in_ready && t < 200) begin
            @(posedge clk); @(negedge clk); t++;
         end
         if (!in_ready) chk("load.in_ready", in_ready, 1);
         in_valid = 1'b1;
         in_data  = (i < NW) ? a[i] : b[i-NW];
         @(posedge clk); @(negedge clk);
         hs_cyc   = cyc;
         in_valid = 1'b0;
      end
   endtask

   // mode 0: out_ready always high, 1: toggles 1,0,1,0..., 2: random
   task automatic drain(input words_t exp, input int mode, input int unsigned hs_cyc,
                        input bit chk_time, input logic [2:0] op, input string tag);
      int t, i, phase;
      int unsigned first, last_hs;
      bit rdy;
      logic [38:0] o, e;
      t = 0;
      out_ready = 1'b0;
      while (!out_valid && t < 100) begin
         chk({tag, ".wait_in_ready"}, in_ready, 0);
         @(posedge clk); @(negedge clk); t++;
      end
      if (!out_valid) begin
         chk({tag, ".valid_timeout"}, out_valid, 1);
         return;
      end
      first = cyc;
      // Handshake in cycle k -> first valid in cycle k+LAT+2.
      if (chk_time) chk({tag, ".latency"}, first - hs_cyc, LAT + 1);
      i = 0; t = 0; phase = 0; last_hs = first;
      while (i < NW && t < 1000) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (phase % 2 == 0);
            default: rdy = 1'($urandom_range(1, 0));
         endcase
         phase++;
         out_ready = rdy;
         o = {out_valid, out_last, in_ready, busy, alu_opcode, out_data};
         e = {1'b1, (i == NW - 1), 1'b0, 1'b1, op, exp[i]};
         chk($sformatf("%s.word%0d", tag, i), o, e);
         if (rdy) begin
            last_hs = cyc;
            i++;
         end
         @(posedge clk); @(negedge clk); t++;
      end
      out_ready = 1'b0;
      if (i < NW) chk({tag, ".drain_timeout"}, i, NW);
      if (mode == 0) chk({tag, ".burst"}, last_hs - first, NW - 1);
   endtask

   task automatic run(input logic [2:0] op, input words_t a, input words_t b,
                      input int gapmax, input int mode, input bit chk_time,
                      input string tag);
      int unsigned hs;
      send_cmd(op, tag);
      load(a, b, gapmax, 2 * NW, hs);
      drain(ref_result(op, a, b), mode, hs, chk_time, op, tag);
   endtask

   function automatic words_t rand_words();
      words_t w;
      for (int i = 0; i < NW; i++) w[i] = $urandom;
      return w;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      words_t a, b;
      int unsigned hs;
      logic [2:0] op;

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      a = '0; b = '0;
      a[0] = 32'hAC;
      run(PARITY, a, b, 0, 0, 1, "parity_ac");
      a[0] = 32'hAD;
      run(PARITY, a, b, 0, 0, 1, "parity_ad");

      a[0] = 32'hED; b[0] = 32'hED;
      run(POPCOUNT, a, b, 0, 0, 1, "popcnt_ed");
      a[0] = 32'hAD;
      run(POPCOUNT, a, b, 0, 0, 1, "popcnt_ad");

      a = rand_words(); b = rand_words();
      run(ROTR, a, b, 3, 1, 0, "rotr_toggle");
      a = rand_words(); b = rand_words();
      run(ROTL, a, b, 2, 2, 0, "rotl_random");

      // Abort mid-B with an asynchronous reset pulse away from the clock edge.
      a = rand_words(); b = rand_words();
      send_cmd(POPCOUNT, "abort");
      load(a, b, 1, NW + 10, hs);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a = '0; b = '0;
      a[0] = 32'hED; b[0] = 32'hED;
      run(POPCOUNT, a, b, 0, 0, 1, "post_reset");

      // cmd_valid held through the command must not disturb it, then is
      // taken the cycle after the final result handshake.
      send_cmd(POPCOUNT, "hold");
      cmd_valid  = 1'b1;
      cmd_opcode = 3'd6;
      load(a, b, 1, 2 * NW, hs);
      drain(ref_result(POPCOUNT, a, b), 0, hs, 1, POPCOUNT, "hold");
      chk("b2b.cmd_ready", {cmd_ready, busy}, {1'b1, 1'b0});
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b.accept", {busy, alu_opcode}, {1'b1, 3'd6});
      a = rand_words(); b = rand_words();
      load(a, b, 0, 2 * NW, hs);
      drain(ref_result(3'd6, a, b), 2, hs, 1, 3'd6, "b2b");

      for (int k = 0; k < 4; k++) begin
         op = 3'($urandom_range(7, 0));
         a = rand_words(); b = rand_words();
         run(op, a, b, 2, 2, 0, $sformatf("rand%0d_op%0d", k, op));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
